rx_frame_sync: RTL and testbench



---
 rtl/rx_frame_pkg.sv | 38 +++
 rtl/rx_frame_sync_crc.sv | 42 ++++
 rtl/rx_frame_sync.sv | 251 +++++++++++++++++++++++++
 tb/tb_rx_frame_sync.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the rx_frame_sync receive front end.
// Holds the FSM state encoding, CRC-16/CCITT-FALSE constants, header
// geometry and a one-bit CRC update helper.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HDR  = 2'd1,
        PASS = 2'd2,
        HOLD = 2'd3
    } rx_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam int HDR_BITS = 32;
    localparam int CRC_BITS = 16;

    // Header field bit positions within the 32-bit header word
    localparam int HDR_TYPE_MSB = 31;
    localparam int HDR_TYPE_LSB = 24;
    localparam int HDR_SEG_MSB  = 23;
    localparam int HDR_SEG_LSB  = 16;
    localparam int HDR_LEN_MSB  = 15;
    localparam int HDR_LEN_LSB  = 0;

    // One serial CRC step, MSB-first, no reflection
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        if (fb) begin
            crc16_step = {crc[14:0], 1'b0} ^ CRC16_POLY;
        end else begin
            crc16_step = {crc[14:0], 1'b0};
        end
    endfunction

endpackage

// File: rtl/rx_frame_sync_crc.sv
// crc16_ccitt_serial: bit-serial CRC-16/CCITT-FALSE engine.
// Ports: clk, rstn (async active-low), init (reload 0xFFFF, wins over en),
//        en (absorb in_bit this cycle), in_bit (data, MSB first),
//        crc[15:0] (registered running CRC).
module crc16_ccitt_serial
    import rx_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        en,
    input  logic        in_bit,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: reload, absorb one bit, or hold
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, in_bit);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rx_frame_sync.sv
// rx_frame_sync: hunts a serial stream for SYNC_WORD, parses the 4-byte
// header, forwards the frame on o_data (DLY+1 cycles late) gated by
// o_data_en, and reports the CRC of the frame minus its trailing 16 bits.
// Ports: i_clk20m, i_rstn (async active-low), i_rx_bit/i_rx_valid (serial in),
//        o_data/o_data_en (delayed frame), o_data_crc/o_data_crc_valid (held
//        CRC result), o_frame_err (abort/reject pulse), o_frame_cnt/o_err_cnt.
// Optional: define RX_FRAME_STAT_EN to build the saturating frame/error
// counters; otherwise both counter ports are constant zero.
module rx_frame_sync
    import rx_frame_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
    parameter int          MAX_BYTES = 1024,
    parameter int          CRC_HOLD  = 160,
    parameter int          DLY       = 32
) (
    input  logic        i_clk20m,
    input  logic        i_rstn,
    input  logic        i_rx_bit,
    input  logic        i_rx_valid,
    output logic        o_data,
    output logic        o_data_en,
    output logic [15:0] o_data_crc,
    output logic        o_data_crc_valid,
    output logic        o_frame_err,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);

    localparam int                HOLD_W      = $clog2(CRC_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(CRC_HOLD - 1);
    localparam logic [16:0]       MAX_BYTES_W = 17'(MAX_BYTES);
    localparam logic [18:0]       HDR_BITS_W  = 19'(HDR_BITS);
    localparam logic [18:0]       CRC_BITS_W  = 19'(CRC_BITS);
    localparam logic [4:0]        HDR_LAST    = 5'(HDR_BITS - 1);

    rx_state_e          state_q, state_d;
    logic [DLY:0]       dly_q, dly_d;
    logic [31:0]        sync_q, sync_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [14:0]        len_hi_q, len_hi_d;
    logic [18:0]        tot_q, tot_d;
    logic [18:0]        in_cnt_q, in_cnt_d;
    logic [18:0]        out_cnt_q, out_cnt_d;
    logic               data_en_q, data_en_d;
    logic [15:0]        crc_out_q, crc_out_d;
    logic               crc_vld_q, crc_vld_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               frame_err_q, frame_err_d;

    logic [31:0] sync_shift_s;
    logic [15:0] len_s;
    logic [16:0] bytes_s;
    logic [18:0] tot_s;
    logic        crc_init_s;
    logic        crc_en_s;
    logic [15:0] crc_s;

    // Frame length decode from the header bits seen so far plus the current bit
    always_comb begin
        sync_shift_s = {sync_q[30:0], i_rx_bit};
        len_s        = {len_hi_q, i_rx_bit};
        bytes_s      = {1'b0, len_s} + 17'd6;
        tot_s        = {bytes_s[15:0], 3'b000};
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        dly_d       = {dly_q[DLY-1:0], i_rx_bit};
        sync_d      = sync_q;
        bit_cnt_d   = bit_cnt_q;
        len_hi_d    = len_hi_q;
        tot_d       = tot_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        data_en_d   = data_en_q;
        crc_out_d   = crc_out_q;
        crc_vld_d   = crc_vld_q;
        hold_d      = hold_q;
        frame_err_d = 1'b0;
        crc_init_s  = 1'b0;
        crc_en_s    = 1'b0;

        case (state_q)
            HUNT: begin
                if (!i_rx_valid) begin
                    sync_d = 32'd0;
                end else if (sync_shift_s == SYNC_WORD) begin
                    // Clearing here means a fresh 32 bits are needed after the frame
                    sync_d     = 32'd0;
                    bit_cnt_d  = 5'd0;
                    crc_init_s = 1'b1;
                    state_d    = HDR;
                end else begin
                    sync_d = sync_shift_s;
                end
            end
            HDR: begin
                if (!i_rx_valid) begin
                    frame_err_d = 1'b1;
                    state_d     = HUNT;
                end else begin
                    crc_en_s  = 1'b1;
                    len_hi_d  = {len_hi_q[13:0], i_rx_bit};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == HDR_LAST) begin
                        if (bytes_s > MAX_BYTES_W) begin
                            frame_err_d = 1'b1;
                            state_d     = HUNT;
                        end else begin
                            // Output counter loads now so o_data_en rises with header bit 0 on o_data
                            tot_d     = tot_s;
                            in_cnt_d  = HDR_BITS_W;
                            out_cnt_d = tot_s;
                            state_d   = PASS;
                        end
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            PASS: begin
                if ((in_cnt_q != tot_q) && !i_rx_valid) begin
                    frame_err_d = 1'b1;
                    data_en_d   = 1'b0;
                    out_cnt_d   = 19'd0;
                    state_d     = HUNT;
                end else begin
                    if (in_cnt_q != tot_q) begin
                        // Trailing CRC field is passed through but not absorbed
                        crc_en_s = (in_cnt_q < (tot_q - CRC_BITS_W));
                        in_cnt_d = in_cnt_q + 19'd1;
                    end else begin
                        in_cnt_d = in_cnt_q;
                    end
                    if (out_cnt_q != 19'd0) begin
                        data_en_d = 1'b1;
                        out_cnt_d = out_cnt_q - 19'd1;
                    end else if (data_en_q) begin
                        data_en_d = 1'b0;
                        crc_out_d = crc_s;
                        crc_vld_d = 1'b1;
                        hold_d    = HOLD_LOAD;
                        state_d   = HOLD;
                    end else begin
                        data_en_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    crc_vld_d = 1'b0;
                    state_d   = HUNT;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk20m or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= HUNT;
            dly_q       <= '0;
            sync_q      <= 32'd0;
            bit_cnt_q   <= 5'd0;
            len_hi_q    <= 15'd0;
            tot_q       <= 19'd0;
            in_cnt_q    <= 19'd0;
            out_cnt_q   <= 19'd0;
            data_en_q   <= 1'b0;
            crc_out_q   <= 16'd0;
            crc_vld_q   <= 1'b0;
            hold_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            sync_q      <= sync_d;
            bit_cnt_q   <= bit_cnt_d;
            len_hi_q    <= len_hi_d;
            tot_q       <= tot_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            data_en_q   <= data_en_d;
            crc_out_q   <= crc_out_d;
            crc_vld_q   <= crc_vld_d;
            hold_q      <= hold_d;
            frame_err_q <= frame_err_d;
        end
    end

    crc16_ccitt_serial u_crc (
        .clk    (i_clk20m),
        .rstn   (i_rstn),
        .init   (crc_init_s),
        .en     (crc_en_s),
        .in_bit (i_rx_bit),
        .crc    (crc_s)
    );

    assign o_data           = dly_q[DLY];
    assign o_data_en        = data_en_q;
    assign o_data_crc       = crc_out_q;
    assign o_data_crc_valid = crc_vld_q;
    assign o_frame_err      = frame_err_q;

`ifdef RX_FRAME_STAT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating counters: accepted frames on CRC-valid rise, errors per pulse
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (crc_vld_d && !crc_vld_q && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        if (frame_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge i_clk20m or negedge i_rstn) begin
        if (!i_rstn) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;
`else
    assign o_frame_cnt = 16'd0;
    assign o_err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_rx_frame_sync.sv
// Directed self-checking bench for rx_frame_sync and its CRC engine.
module tb_rx_frame_sync;

`ifdef RX_FRAME_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic        i_clk20m = 1'b0;
    logic        i_rstn;
    logic        i_rx_bit;
    logic        i_rx_valid;
    logic        o_data;
    logic        o_data_en;
    logic [15:0] o_data_crc;
    logic        o_data_crc_valid;
    logic        o_frame_err;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_err_cnt;

    logic        crc_init_t, crc_en_t, crc_bit_t;
    logic [15:0] crc_out_t;

    rx_frame_sync dut (
        .i_clk20m         (i_clk20m),
        .i_rstn           (i_rstn),
        .i_rx_bit         (i_rx_bit),
        .i_rx_valid       (i_rx_valid),
        .o_data           (o_data),
        .o_data_en        (o_data_en),
        .o_data_crc       (o_data_crc),
        .o_data_crc_valid (o_data_crc_valid),
        .o_frame_err      (o_frame_err),
        .o_frame_cnt      (o_frame_cnt),
        .o_err_cnt        (o_err_cnt)
    );

    crc16_ccitt_serial u_crc_solo (
        .clk    (i_clk20m),
        .rstn   (i_rstn),
        .init   (crc_init_t),
        .en     (crc_en_t),
        .in_bit (crc_bit_t),
        .crc    (crc_out_t)
    );

    always #25 i_clk20m = ~i_clk20m;

    int cyc = 0;
    always @(posedge i_clk20m) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic        hist [0:65535];
    logic [7:0]  fb [0:1023];
    logic [15:0] exp_crc;
    int          hdr_cyc, last_cyc;

    int          en_cnt, en_rise, val_cnt, err_pulses, data_bad, crc_unstable;
    logic [15:0] crc_seen;
    logic        en_prev = 1'b0;
    logic        val_prev = 1'b0;

    // Output monitor, sampled on the inactive edge
    always @(negedge i_clk20m) begin
        int t;
        t = cyc - 33;
        if (o_data_en === 1'b1) begin
            en_cnt++;
            if (!en_prev) en_rise = cyc;
            if (t < 0) data_bad++;
            else if (o_data !== hist[t[15:0]]) data_bad++;
        end
        if (o_data_crc_valid === 1'b1) begin
            if (val_prev && (o_data_crc !== crc_seen)) crc_unstable++;
            crc_seen = o_data_crc;
            val_cnt++;
        end
        if (o_frame_err === 1'b1) err_pulses++;
        en_prev  = (o_data_en === 1'b1);
        val_prev = (o_data_crc_valid === 1'b1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic v);
        @(negedge i_clk20m);
        i_rx_bit   = b;
        i_rx_valid = v;
        hist[cyc[15:0]] = b;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic clear_stats();
        en_cnt = 0; en_rise = -1000; val_cnt = 0; err_pulses = 0;
        data_bad = 0; crc_unstable = 0; crc_seen = 16'd0;
    endtask

    function automatic logic [15:0] model_crc(input int nbytes);
        logic [15:0] c;
        logic [7:0]  byt;
        logic        f;
        c = 16'hFFFF;
        for (int i = 0; i < nbytes; i++) begin
            byt = fb[i];
            for (int j = 7; j >= 0; j--) begin
                f = c[15] ^ byt[j];
                c = {c[14:0], 1'b0};
                if (f) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic send_sync();
        logic [31:0] sw;
        sw = 32'h1ACF_FC1D;
        for (int i = 31; i >= 0; i--) step(sw[i], 1'b1);
    endtask

    // mode 0: full frame; 1: valid low at bit 'cut'; 2: stop before bit 'cut'; 3: header only
    task automatic send_frame(input int len, input int cut, input int mode, input bit emb);
        int n, nb;
        logic [7:0] byt;
        logic       b;
        logic [15:0] l16;
        l16 = 16'(len);
        n = (mode == 3) ? 4 : len + 6;
        fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = l16[15:8]; fb[3] = l16[7:0];
        if (mode != 3) begin
            for (int i = 4; i < n - 2; i++) fb[i] = 8'(i * 37 + 5);
            if (emb) begin
                fb[6] = 8'h1A; fb[7] = 8'hCF; fb[8] = 8'hFC; fb[9] = 8'h1D;
            end
            exp_crc = model_crc(n - 2);
            fb[n-2] = exp_crc[15:8];
            fb[n-1] = exp_crc[7:0];
        end
        send_sync();
        nb = n * 8;
        for (int k = 0; k < nb; k++) begin
            byt = fb[k >> 3];
            b = byt[3'(7 - (k & 7))];
            if ((mode == 1 || mode == 2) && k == cut) begin
                if (mode == 1) step(b, 1'b0);
                break;
            end
            step(b, 1'b1);
            if (k == 0) hdr_cyc = last_cyc;
        end
    endtask

    initial begin
        logic [71:0] s;
        i_rstn = 1'b0; i_rx_bit = 1'b0; i_rx_valid = 1'b0;
        crc_init_t = 1'b0; crc_en_t = 1'b0; crc_bit_t = 1'b0;
        clear_stats();
        idle(3);
        check("rst_data", int'(o_data), 0);
        check("rst_en", int'(o_data_en), 0);
        check("rst_crc", int'(o_data_crc), 0);
        check("rst_crc_valid", int'(o_data_crc_valid), 0);
        check("rst_err", int'(o_frame_err), 0);
        check("rst_fcnt", int'(o_frame_cnt), 0);
        check("rst_ecnt", int'(o_err_cnt), 0);
        check("rst_solo_crc", int'(crc_out_t), 16'hFFFF);
        i_rstn = 1'b1;
        idle(2);

        // Standalone CRC engine on the check string
        s = "123456789";
        @(negedge i_clk20m); crc_init_t = 1'b1;
        @(negedge i_clk20m); crc_init_t = 1'b0; crc_en_t = 1'b1;
        for (int i = 71; i >= 0; i--) begin
            crc_bit_t = s[i];
            @(negedge i_clk20m);
        end
        crc_en_t = 1'b0;
        check("crc_check_string", int'(crc_out_t), 16'h29B1);

        // LEN=0 frame: 48 enabled cycles
        clear_stats();
        send_frame(0, -1, 0, 1'b0);
        idle(230);
        check("len0_en_cycles", en_cnt, 48);
        check("len0_en_latency", en_rise - hdr_cyc, 33);
        check("len0_data", data_bad, 0);
        check("len0_crc", int'(crc_seen), int'(model_crc(4)));
        check("len0_crc_valid_cycles", val_cnt, 160);
        check("len0_crc_stable", crc_unstable, 0);
        check("len0_err", err_pulses, 0);

        // Reset in the middle of a LEN=16 frame
        send_frame(16, 100, 2, 1'b0);
        check("midrst_en_before", int'(o_data_en), 1);
        #10 i_rstn = 1'b0;
        #1;
        check("midrst_en", int'(o_data_en), 0);
        check("midrst_data", int'(o_data), 0);
        check("midrst_crc_valid", int'(o_data_crc_valid), 0);
        check("midrst_crc", int'(o_data_crc), 0);
        check("midrst_fcnt", int'(o_frame_cnt), 0);
        idle(3);
        i_rstn = 1'b1;
        idle(2);

        // Embedded sync in payload, plus a sync during HOLD
        clear_stats();
        send_frame(8, -1, 0, 1'b1);
        idle(40);
        send_sync();
        repeat (32) step(1'b0, 1'b1);
        idle(250);
        check("emb_en_cycles", en_cnt, 112);
        check("emb_crc_valid_cycles", val_cnt, 160);
        check("emb_data", data_bad, 0);
        check("emb_crc", int'(crc_seen), int'(exp_crc));
        check("emb_err", err_pulses, 0);
        check("emb_fcnt", int'(o_frame_cnt), STAT * 1);

        // Largest accepted frame
        clear_stats();
        send_frame(16'h03FA, -1, 0, 1'b0);
        idle(230);
        check("max_en_cycles", en_cnt, 8192);
        check("max_en_latency", en_rise - hdr_cyc, 33);
        check("max_data", data_bad, 0);
        check("max_crc", int'(crc_seen), int'(exp_crc));
        check("max_crc_valid_cycles", val_cnt, 160);

        // One byte too long: rejected after header
        clear_stats();
        send_frame(16'h03FB, -1, 3, 1'b0);
        idle(60);
        check("rej_en_cycles", en_cnt, 0);
        check("rej_err_pulses", err_pulses, 1);
        check("rej_crc_valid", val_cnt, 0);
        check("rej_ecnt", int'(o_err_cnt), STAT * 1);

        // Valid drops at payload bit 100 of a LEN=16 frame
        clear_stats();
        send_frame(16, 132, 1, 1'b0);
        idle(230);
        check("abort_en_cycles", en_cnt, 100);
        check("abort_err_pulses", err_pulses, 1);
        check("abort_crc_valid", val_cnt, 0);
        check("abort_data", data_bad, 0);
        check("abort_en_low", int'(o_data_en), 0);

        // Clean frame after the abort
        clear_stats();
        send_frame(2, -1, 0, 1'b0);
        idle(230);
        check("after_en_cycles", en_cnt, 64);
        check("after_data", data_bad, 0);
        check("after_crc", int'(crc_seen), int'(exp_crc));
        check("after_crc_valid_cycles", val_cnt, 160);
        check("after_err", err_pulses, 0);
        check("after_fcnt", int'(o_frame_cnt), STAT * 3);
        check("after_ecnt", int'(o_err_cnt), STAT * 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
